// File: rtl/apb_uart_regs_pkg.sv
// apb_uart_pkg: shared definitions for the APB UART register front-end.
//   - register byte offsets and their word indices (paddr[4:2])
//   - STATUS / CTRL bit positions
//   - bus FSM state type
//   - default baud divisor
package apb_uart_pkg;

  localparam logic [4:0] TXDATA_OFS   = 5'h00;
  localparam logic [4:0] RXDATA_OFS   = 5'h04;
  localparam logic [4:0] STATUS_OFS   = 5'h08;
  localparam logic [4:0] CTRL_OFS     = 5'h0C;
  localparam logic [4:0] BAUD_DIV_OFS = 5'h10;

  // Word index of each register as decoded from paddr[4:2].
  localparam logic [2:0] TXDATA_IDX   = TXDATA_OFS[4:2];
  localparam logic [2:0] RXDATA_IDX   = RXDATA_OFS[4:2];
  localparam logic [2:0] STATUS_IDX   = STATUS_OFS[4:2];
  localparam logic [2:0] CTRL_IDX     = CTRL_OFS[4:2];
  localparam logic [2:0] BAUD_DIV_IDX = BAUD_DIV_OFS[4:2];

  // STATUS bits: [1:0] live FIFO flags, [4:2] sticky, write-1-to-clear.
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_ERR   = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_RX_UNF   = 4;

  // CTRL bits.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE_RX  = 1;
  localparam int CTRL_IE_TX  = 2;
  localparam int CTRL_IE_ERR = 3;
  localparam int CTRL_W      = 4;

  localparam logic [15:0] DIV_RST_DEF = 16'd53;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_WAIT = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_uart_regs_if.sv
// apb_uart_regs_if: APB3 bus bundle.
//   master modport: drives paddr/psel/penable/pwrite/pwdata, samples prdata/pready/pslverr
//   slave  modport: the reverse
interface apb_uart_regs_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_uart_regs_baud_gen.sv
// uart_baud_gen: programmable 16x baud tick generator.
//   clk, rst : clock, synchronous active-high reset
//   en       : run enable; when low the counter is held at 0 and tick is 0
//   div      : divisor, tick period is div+1 clocks (div=0 -> every clock)
//   div_wr   : divisor being rewritten; restarts the count from 0
//   tick     : one-cycle pulse on the counter wrap cycle
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             div_wr,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic             wrap;

  // >= rather than == so a counter that somehow sits above the divisor
  // still wraps instead of running all the way round.
  assign wrap = (cnt_reg >= div);
  assign tick = en & wrap;

  always_comb begin
    cnt_next = cnt_reg;
    if (!en || div_wr || wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/apb_uart_regs.sv
// apb_uart_regs: APB3 slave register front-end for uart_top.
//   clk, rst       : clock, synchronous active-high reset
//   apb            : APB3 slave port (paddr/psel/penable/pwrite/pwdata in,
//                    prdata/pready/pslverr out)
//   tick           : 16x baud tick to uart_top
//   tx_fifo_*      : TX FIFO push port (wr_en, din out; full in)
//   rx_fifo_*      : RX FIFO pop port (rd_en out; dout, empty in)
//   rx_error       : parity/framing error pulse from uart_top
//   irq            : registered level interrupt
// Registers: TXDATA, RXDATA, STATUS (live + sticky W1C), CTRL, BAUD_DIV.
module apb_uart_regs
  import apb_uart_pkg::*;
#(
  parameter int              DATA_BITS = 8,
  parameter int              ADDR_W    = 5,
  parameter int              DIV_W     = 16,
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_RST_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_uart_regs_if.slave       apb,
  output logic                 tick,
  output logic                 tx_fifo_wr_en,
  output logic [DATA_BITS-1:0] tx_fifo_din,
  input  logic                 tx_fifo_full,
  output logic                 rx_fifo_rd_en,
  input  logic [DATA_BITS-1:0] rx_fifo_dout,
  input  logic                 rx_fifo_empty,
  input  logic                 rx_error,
  output logic                 irq
);

  apb_state_e        state_reg, state_next;
  logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic              div_wr;
  logic              rx_err_reg, tx_ovf_reg, rx_unf_reg;
  logic              set_tx_ovf, set_rx_unf;
  logic              clr_rx_err, clr_tx_ovf, clr_rx_unf;
  logic              irq_reg, irq_next;
  logic [2:0]        reg_idx;
  logic              access;
  logic [31:0]       status_word;
  logic              unused_bits;

  // Only the word index and the low data bits are decoded; the rest of the
  // bus is folded here so it is visibly consumed.
  assign unused_bits = ^{apb.paddr, apb.pwdata};

  assign reg_idx = apb.paddr[4:2];
  assign access  = apb.psel & apb.penable;

  always_comb begin
    status_word              = '0;
    status_word[ST_RX_EMPTY] = rx_fifo_empty;
    status_word[ST_TX_FULL]  = tx_fifo_full;
    status_word[ST_RX_ERR]   = rx_err_reg;
    status_word[ST_TX_OVF]   = tx_ovf_reg;
    status_word[ST_RX_UNF]   = rx_unf_reg;
  end

  // Bus FSM: next state, bus responses, FIFO strobes and register updates.
  always_comb begin
    state_next    = state_reg;
    apb.pready    = 1'b0;
    apb.pslverr   = 1'b0;
    apb.prdata    = '0;
    tx_fifo_wr_en = 1'b0;
    tx_fifo_din   = '0;
    rx_fifo_rd_en = 1'b0;
    ctrl_next     = ctrl_reg;
    div_next      = div_reg;
    div_wr        = 1'b0;
    set_tx_ovf    = 1'b0;
    set_rx_unf    = 1'b0;
    clr_rx_err    = 1'b0;
    clr_tx_ovf    = 1'b0;
    clr_rx_unf    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_next = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (!access) begin
          // Master abandoned the transfer; a fresh setup phase keeps us here.
          state_next = (apb.psel && !apb.penable) ? ST_ACCESS : ST_IDLE;
        end else begin
          apb.pready = 1'b1;
          state_next = ST_IDLE;
          case (reg_idx)
            TXDATA_IDX: begin
              if (apb.pwrite) begin
                if (tx_fifo_full) begin
                  apb.pslverr = 1'b1;
                  set_tx_ovf  = 1'b1;
                end else begin
                  tx_fifo_wr_en = 1'b1;
                  tx_fifo_din   = apb.pwdata[DATA_BITS-1:0];
                end
              end
            end
            RXDATA_IDX: begin
              if (!apb.pwrite) begin
                if (rx_fifo_empty) begin
                  apb.pslverr = 1'b1;
                  set_rx_unf  = 1'b1;
                end else begin
                  // FIFO data appears the cycle after the pop, so insert
                  // exactly one wait state and return it from RD_WAIT.
                  apb.pready    = 1'b0;
                  rx_fifo_rd_en = 1'b1;
                  state_next    = ST_RD_WAIT;
                end
              end
            end
            STATUS_IDX: begin
              if (apb.pwrite) begin
                clr_rx_err = apb.pwdata[ST_RX_ERR];
                clr_tx_ovf = apb.pwdata[ST_TX_OVF];
                clr_rx_unf = apb.pwdata[ST_RX_UNF];
              end else begin
                apb.prdata = status_word;
              end
            end
            CTRL_IDX: begin
              if (apb.pwrite) begin
                ctrl_next = apb.pwdata[CTRL_W-1:0];
              end else begin
                apb.prdata = 32'(ctrl_reg);
              end
            end
            BAUD_DIV_IDX: begin
              if (apb.pwrite) begin
                div_next = apb.pwdata[DIV_W-1:0];
                div_wr   = 1'b1;
              end else begin
                apb.prdata = 32'(div_reg);
              end
            end
            default: begin
              apb.pslverr = 1'b1;
            end
          endcase
        end
      end

      ST_RD_WAIT: begin
        apb.pready = 1'b1;
        apb.prdata = 32'(rx_fifo_dout);
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    irq_next = (ctrl_reg[CTRL_IE_RX]  & ~rx_fifo_empty) |
               (ctrl_reg[CTRL_IE_TX]  & ~tx_fifo_full)  |
               (ctrl_reg[CTRL_IE_ERR] & (rx_err_reg | tx_ovf_reg | rx_unf_reg));
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      ctrl_reg   <= '0;
      div_reg    <= DIV_RST;
      rx_err_reg <= 1'b0;
      tx_ovf_reg <= 1'b0;
      rx_unf_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ctrl_reg   <= ctrl_next;
      div_reg    <= div_next;
      rx_err_reg <= rx_error   | (rx_err_reg & ~clr_rx_err);
      tx_ovf_reg <= set_tx_ovf | (tx_ovf_reg & ~clr_tx_ovf);
      rx_unf_reg <= set_rx_unf | (rx_unf_reg & ~clr_rx_unf);
      irq_reg    <= irq_next;
    end
  end

  assign irq = irq_reg;

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_reg[CTRL_EN]),
    .div   (div_reg),
    .div_wr(div_wr),
    .tick  (tick)
  );

endmodule

// File: tb/tb_apb_uart_regs.sv
// tb_apb_uart_regs: directed, table-driven bench for apb_uart_regs.
// A small RX FIFO model feeds rx_fifo_dout/empty; TX pushes are logged.
module tb_apb_uart_regs;
  import apb_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       tx_fifo_wr_en;
  logic [7:0] tx_fifo_din;
  logic       tx_fifo_full;
  logic       rx_fifo_rd_en;
  logic [7:0] rx_fifo_dout;
  logic       rx_fifo_empty;
  logic       rx_error;
  logic       irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_uart_regs_if #(.ADDR_W(5)) bus ();

  apb_uart_regs #(
    .DATA_BITS(8),
    .ADDR_W   (5),
    .DIV_W    (16),
    .DIV_RST  (16'd53)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .apb          (bus),
    .tick         (tick),
    .tx_fifo_wr_en(tx_fifo_wr_en),
    .tx_fifo_din  (tx_fifo_din),
    .tx_fifo_full (tx_fifo_full),
    .rx_fifo_rd_en(rx_fifo_rd_en),
    .rx_fifo_dout (rx_fifo_dout),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_error     (rx_error),
    .irq          (irq)
  );

  // RX FIFO model: the initial block pushes via rx_wp, pops move rx_rp.
  logic [7:0] rx_mem [0:15];
  logic [3:0] rx_wp = 4'd0;
  logic [3:0] rx_rp = 4'd0;
  assign rx_fifo_empty = (rx_rp == rx_wp);

  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] tx_log [0:15];

  always @(posedge clk) begin
    if (rx_fifo_rd_en && !rx_fifo_empty) begin
      rx_fifo_dout <= rx_mem[rx_rp];
      rx_rp        <= rx_rp + 4'd1;
    end
    if (rx_fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (tx_fifo_wr_en) begin
      tx_log[wr_cnt % 16] <= tx_fifo_din;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_mem[rx_wp] = d;
    rx_wp         = rx_wp + 4'd1;
  endtask

  // One APB transfer; err_pulse raises rx_error during the access cycle.
  task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                     input logic err_pulse, output logic [31:0] rdata,
                     output logic err, output int waits);
    bit done = 0;
    rdata = '0;
    err   = 1'b0;
    waits = 0;
    @(posedge clk); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = addr;
    bus.pwrite  = wr;
    bus.pwdata  = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    rx_error    = err_pulse;
    while (!done && waits < 8) begin
      @(negedge clk);
      if (bus.pready) begin
        rdata = bus.prdata;
        err   = bus.pslverr;
        done  = 1;
      end else begin
        waits++;
      end
    end
    if (!done) check("pready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    rx_error    = 1'b0;
    $display("apb %s addr=0x%02h wdata=0x%08h rdata=0x%08h pslverr=%0b waits=%0d",
             wr ? "WR" : "RD", addr, wdata, rdata, err, waits);
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;
    int          base;
    int          n;
    int          bad;

    vecs[0]  = '{1'b0, CTRL_OFS,     32'h0,        32'h0,    1'b0};
    vecs[1]  = '{1'b0, BAUD_DIV_OFS, 32'h0,        32'h35,   1'b0};
    vecs[2]  = '{1'b0, STATUS_OFS,   32'h0,        32'h01,   1'b0};
    vecs[3]  = '{1'b0, TXDATA_OFS,   32'h0,        32'h0,    1'b0};
    vecs[4]  = '{1'b0, 5'h14,        32'h0,        32'h0,    1'b1};
    vecs[5]  = '{1'b1, 5'h18,        32'hFF,       32'h0,    1'b1};
    vecs[6]  = '{1'b0, 5'h1C,        32'h0,        32'h0,    1'b1};
    vecs[7]  = '{1'b1, RXDATA_OFS,   32'h55,       32'h0,    1'b0};
    vecs[8]  = '{1'b1, CTRL_OFS,     32'hFF,       32'h0,    1'b0};
    vecs[9]  = '{1'b0, CTRL_OFS,     32'h0,        32'h0F,   1'b0};
    vecs[10] = '{1'b1, CTRL_OFS,     32'h0,        32'h0,    1'b0};
    vecs[11] = '{1'b0, CTRL_OFS,     32'h0,        32'h0,    1'b0};
    vecs[12] = '{1'b1, BAUD_DIV_OFS, 32'hFFFF1234, 32'h0,    1'b0};
    vecs[13] = '{1'b0, BAUD_DIV_OFS, 32'h0,        32'h1234, 1'b0};
    vecs[14] = '{1'b1, BAUD_DIV_OFS, 32'h3,        32'h0,    1'b0};
    vecs[15] = '{1'b0, BAUD_DIV_OFS, 32'h0,        32'h3,    1'b0};
    vecs[16] = '{1'b0, STATUS_OFS,   32'h0,        32'h01,   1'b0};

    rst          = 1'b1;
    tx_fifo_full = 1'b0;
    rx_error     = 1'b0;
    bus.psel     = 1'b0;
    bus.penable  = 1'b0;
    bus.pwrite   = 1'b0;
    bus.paddr    = '0;
    bus.pwdata   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready",  32'(bus.pready),     32'd0);
    check("rst_pslverr", 32'(bus.pslverr),    32'd0);
    check("rst_prdata",  bus.prdata,          32'd0);
    check("rst_strobes", 32'({tx_fifo_wr_en, rx_fifo_rd_en}), 32'd0);
    check("rst_irq_tick", 32'({irq, tick}),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Register map, table driven.
    base = rd_cnt;
    for (int i = 0; i < 17; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, w);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
    end
    check("table_no_pop", 32'(rd_cnt - base), 32'd0);
    check("irq_ctrl0", 32'(irq), 32'd0);

    // Tick generator: BAUD_DIV=3 from the table, period 4.
    apb(1'b1, CTRL_OFS, 32'h1, 1'b0, rd, er, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    check("tick_seen", 32'(tick), 32'd1);
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (tick !== ((k % 4) == 0)) bad++;
    end
    check("tick_period4", 32'(bad), 32'd0);
    apb(1'b1, CTRL_OFS, 32'h0, 1'b0, rd, er, w);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tick !== 1'b0) bad++;
    end
    check("tick_off", 32'(bad), 32'd0);

    // TX pushes and overflow.
    base = wr_cnt;
    apb(1'b1, TXDATA_OFS, 32'hFFFF_FFA5, 1'b0, rd, er, w);
    check("tx_a5_pslverr", 32'(er), 32'd0);
    apb(1'b1, TXDATA_OFS, 32'h3C, 1'b0, rd, er, w);
    check("tx_3c_pslverr", 32'(er), 32'd0);
    check("tx_push_count", 32'(wr_cnt - base), 32'd2);
    check("tx_din0", 32'(tx_log[base % 16]), 32'hA5);
    check("tx_din1", 32'(tx_log[(base + 1) % 16]), 32'h3C);
    tx_fifo_full = 1'b1;
    apb(1'b1, TXDATA_OFS, 32'h77, 1'b0, rd, er, w);
    check("tx_ovf_pslverr", 32'(er), 32'd1);
    check("tx_ovf_no_push", 32'(wr_cnt - base), 32'd2);
    apb(1'b0, STATUS_OFS, 32'h0, 1'b0, rd, er, w);
    check("status_tx_ovf", rd, 32'h0B);
    tx_fifo_full = 1'b0;

    // RX pop with one wait state, then underflow.
    rx_push(8'h5A);
    base = rd_cnt;
    apb(1'b0, RXDATA_OFS, 32'h0, 1'b0, rd, er, w);
    check("rx_data", rd, 32'h5A);
    check("rx_pslverr", 32'(er), 32'd0);
    check("rx_waits", 32'(w), 32'd1);
    check("rx_one_pop", 32'(rd_cnt - base), 32'd1);
    apb(1'b0, RXDATA_OFS, 32'h0, 1'b0, rd, er, w);
    check("rx_unf_data", rd, 32'h0);
    check("rx_unf_pslverr", 32'(er), 32'd1);
    check("rx_unf_waits", 32'(w), 32'd0);
    check("rx_unf_no_pop", 32'(rd_cnt - base), 32'd1);
    apb(1'b0, STATUS_OFS, 32'h0, 1'b0, rd, er, w);
    check("status_rx_unf", rd, 32'h19);

    // rx_error pulse, then W1C racing a fresh pulse: set wins.
    @(posedge clk); #1; rx_error = 1'b1;
    @(posedge clk); #1; rx_error = 1'b0;
    apb(1'b0, STATUS_OFS, 32'h0, 1'b0, rd, er, w);
    check("status_all_sticky", rd, 32'h1D);
    apb(1'b1, STATUS_OFS, 32'h1C, 1'b1, rd, er, w);
    apb(1'b0, STATUS_OFS, 32'h0, 1'b0, rd, er, w);
    check("w1c_set_wins", rd, 32'h05);
    apb(1'b1, STATUS_OFS, 32'h1C, 1'b0, rd, er, w);
    apb(1'b0, STATUS_OFS, 32'h0, 1'b0, rd, er, w);
    check("w1c_cleared", rd, 32'h01);

    // Interrupt: ie_rx with a non-empty RX FIFO, then pop to empty.
    rx_push(8'h11);
    apb(1'b1, CTRL_OFS, 32'h3, 1'b0, rd, er, w);
    check("irq_latency0", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_rx_set", 32'(irq), 32'd1);
    apb(1'b0, RXDATA_OFS, 32'h0, 1'b0, rd, er, w);
    check("irq_pop_data", rd, 32'h11);
    check("irq_rx_clear", 32'(irq), 32'd0);

    // Reset while waiting in RD_WAIT.
    rx_push(8'h22);
    base = rd_cnt;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = RXDATA_OFS; bus.pwrite = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    check("rdw_rd_en", 32'({rx_fifo_rd_en, bus.pready}), 32'b10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rdw_rst_pready", 32'(bus.pready), 32'd0);
    check("rdw_rst_outs", 32'({bus.pslverr, rx_fifo_rd_en, tx_fifo_wr_en, irq, tick}), 32'd0);
    check("rdw_rst_prdata", bus.prdata, 32'd0);
    $display("rst asserted during RD_WAIT, pready=%0b prdata=0x%08h", bus.pready, bus.prdata);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rdw_single_pop", 32'(rd_cnt - base), 32'd1);
    apb(1'b0, CTRL_OFS, 32'h0, 1'b0, rd, er, w);
    check("post_rst_ctrl", rd, 32'h0);
    apb(1'b0, BAUD_DIV_OFS, 32'h0, 1'b0, rd, er, w);
    check("post_rst_baud", rd, 32'h35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
